// File: rtl/store_checker_pkg.sv
// Shared types and constants for the store checker.
package store_checker_pkg;

    // Checker phases: loading expectations, checking stores, verdicts.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    // One expected store.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    // Width of store_count / fail_index.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment for the matched-store counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/store_checker_fifo.sv
// chk_fifo: synchronous FIFO holding the expected-store entries.
module chk_fifo
    import store_checker_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Read/write pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/store_checker.sv
// store_checker: compares CPU stores against a preloaded list of expected
// stores and reports pass/fail, with an idle timeout and skip-address filter.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] SKIP_ADDR = 32'h50,
    parameter int          SKIP_EN   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    input  logic             exp_load,
    input  logic [31:0]      exp_addr,
    input  logic [31:0]      exp_data,
    input  logic             start,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             overflow,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] fail_index
);

    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;

    logic              done_d;
    logic              pass_d;
    logic              fail_d;
    logic              timeout_d;
    logic              overflow_d;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  fidx_d;

    entry_t            head;
    entry_t            din;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              do_push;

    logic              running;
    logic              skip_store;
    logic              cmp_store;
    logic              match;
    logic              mismatch;
    logic              idle_tick;
    logic              timeout_hit;

    assign din = '{addr: exp_addr, data: exp_data};

    // Store classification for the current edge.
    always_comb begin
        running     = (state_q == RUN);
        skip_store  = running && memwrite && (SKIP_EN != 0) && (dataadr == SKIP_ADDR);
        cmp_store   = running && memwrite && !skip_store;
        match       = cmp_store && (dataadr == head.addr) && (writedata == head.data);
        mismatch    = cmp_store && !match;
        // Skipped stores freeze the idle counter rather than advancing it.
        idle_tick   = running && !skip_store && !match;
        // A mismatch on the same edge takes priority over the idle limit.
        timeout_hit = idle_tick && !mismatch && (idle_q == IDLE_LIMIT);
        do_push     = (state_q == LOAD) && exp_load && !full;
    end

    chk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (match),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (start)
                    state_d = empty ? PASS : RUN;
            end
            RUN: begin
                if (mismatch)
                    state_d = FAIL;
                else if (match && (level == LVL_W'(1)))
                    state_d = PASS;
                else if (timeout_hit)
                    state_d = FAIL;
            end
            default: state_d = state_q;
        endcase
    end

    // Next values of the registered outputs and idle counter.
    always_comb begin
        done_d     = (state_d == PASS) || (state_d == FAIL);
        pass_d     = (state_d == PASS);
        fail_d     = (state_d == FAIL);
        timeout_d  = timeout | timeout_hit;
        overflow_d = overflow | ((state_q == LOAD) && exp_load && full);
        count_d    = match ? sat_inc(store_count) : store_count;
        fidx_d     = (mismatch || timeout_hit) ? store_count : fail_index;
        idle_d     = idle_q;
        if (match)
            idle_d = '0;
        else if (idle_tick)
            idle_d = idle_q + IDLE_W'(1);
    end

    // Output and idle-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            store_count <= '0;
            fail_index  <= '0;
            idle_q      <= '0;
        end else begin
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timeout     <= timeout_d;
            overflow    <= overflow_d;
            store_count <= count_d;
            fail_index  <= fidx_d;
            idle_q      <= idle_d;
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker: directed scenarios plus randomized
// sessions, compared every cycle against a queue-based reference model.
module tb_store_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] SKIP = 32'h50;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        exp_load;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        start;
    logic        done, pass, fail, timeout, overflow;
    logic [7:0]  store_count, fail_index;

    int total = 0;
    int bad   = 0;

    store_checker #(
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .SKIP_ADDR (SKIP),
        .SKIP_EN   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .exp_load    (exp_load),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .start       (start),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .overflow    (overflow),
        .store_count (store_count),
        .fail_index  (fail_index)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mq[$];
    bit m_armed, m_done, m_pass, m_fail, m_to, m_ovf;
    int m_cnt, m_fidx, m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_armed = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0;
        m_cnt = 0; m_fidx = 0; m_idle = 0;
    endtask

    task automatic model_edge();
        bit was_empty;
        if (reset) begin
            model_clear();
        end else if (!m_done) begin
            if (!m_armed) begin
                was_empty = (mq.size() == 0);
                if (exp_load) begin
                    if (mq.size() == DEPTH) m_ovf = 1;
                    else mq.push_back({exp_addr, exp_data});
                end
                if (start) begin
                    if (was_empty) begin m_done = 1; m_pass = 1; end
                    else m_armed = 1;
                end
            end else if (memwrite && dataadr == SKIP) begin
                // ignored entirely
            end else if (memwrite) begin
                if ({dataadr, writedata} == mq[0]) begin
                    void'(mq.pop_front());
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_idle = 0;
                    if (mq.size() == 0) begin m_done = 1; m_pass = 1; end
                end else begin
                    m_done = 1; m_fail = 1; m_fidx = m_cnt;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_done = 1; m_fail = 1; m_to = 1; m_fidx = m_cnt;
                end
            end
        end
    endtask

    // Single compare process: model advances on each edge, outputs checked 1 time unit later.
    always @(posedge clk) begin
        model_edge();
        #1;
        chk("done",        32'(done),        32'(m_done));
        chk("pass",        32'(pass),        32'(m_pass));
        chk("fail",        32'(fail),        32'(m_fail));
        chk("timeout",     32'(timeout),     32'(m_to));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("store_count", 32'(store_count), 32'(m_cnt));
        chk("fail_index",  32'(fail_index),  32'(m_fidx));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_load = 1; exp_addr = a; exp_data = d;
        cyc();
        exp_load = 0;
    endtask

    task automatic do_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        cyc();
        memwrite = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        chk("rst_done",  32'(done),        0);
        chk("rst_pass",  32'(pass),        0);
        chk("rst_fail",  32'(fail),        0);
        chk("rst_to",    32'(timeout),     0);
        chk("rst_ovf",   32'(overflow),    0);
        chk("rst_cnt",   32'(store_count), 0);
        chk("rst_fidx",  32'(fail_index),  0);
        cyc();
        reset = 0;
    endtask

    initial begin
        logic [31:0] a, d;
        int n, r;
        reset = 1; memwrite = 0; dataadr = '0; writedata = '0;
        exp_load = 0; exp_addr = '0; exp_data = '0; start = 0;
        cyc();
        cyc();
        reset = 0;
        cyc();

        // Two matched stores -> pass
        do_reset();
        push(32'h54, 32'h7);
        push(32'h52, 32'hFFFF7F02);
        do_start();
        store(32'h54, 32'h7);
        chk("two_mid_pass", 32'(pass), 0);
        store(32'h52, 32'hFFFF7F02);
        chk("two_pass",  32'(pass),        1);
        chk("two_cnt",   32'(store_count), 2);
        chk("two_done",  32'(done),        1);

        // Data mismatch -> fail at index 0
        do_reset();
        push(32'h54, 32'h5);
        do_start();
        store(32'h54, 32'h6);
        chk("mm_fail", 32'(fail),       1);
        chk("mm_fidx", 32'(fail_index), 0);
        chk("mm_to",   32'(timeout),    0);

        // Skip address store is ignored
        do_reset();
        push(32'h54, 32'h5);
        do_start();
        store(32'h50, 32'h1);
        store(32'h54, 32'h5);
        chk("skip_pass", 32'(pass),        1);
        chk("skip_cnt",  32'(store_count), 1);

        // Idle timeout
        do_reset();
        push(32'h54, 32'h5);
        do_start();
        repeat (TIMEOUT - 1) cyc();
        chk("to_early", 32'(fail), 0);
        cyc();
        chk("to_fail", 32'(fail),    1);
        chk("to_flag", 32'(timeout), 1);

        // Mismatch on the timeout edge wins
        do_reset();
        push(32'h54, 32'h5);
        do_start();
        repeat (TIMEOUT - 1) cyc();
        store(32'h54, 32'h9);
        chk("mmto_fail", 32'(fail),    1);
        chk("mmto_to",   32'(timeout), 0);

        // Overflow: DEPTH+1 pushes, only DEPTH compared
        do_reset();
        for (int i = 0; i <= DEPTH; i++) push(32'h100 + 32'(4 * i), 32'(i));
        chk("ovf_flag", 32'(overflow), 1);
        do_start();
        for (int i = 0; i < DEPTH; i++) store(32'h100 + 32'(4 * i), 32'(i));
        chk("ovf_pass", 32'(pass),        1);
        chk("ovf_cnt",  32'(store_count), DEPTH);

        // Reset mid-RUN, then a fresh session
        do_reset();
        push(32'h54, 32'h7);
        push(32'h58, 32'h8);
        do_start();
        store(32'h54, 32'h7);
        chk("mid_cnt", 32'(store_count), 1);
        do_reset();
        push(32'h60, 32'h9);
        do_start();
        store(32'h60, 32'h9);
        chk("fresh_pass", 32'(pass),        1);
        chk("fresh_cnt",  32'(store_count), 1);

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            do_reset();
            n = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    memwrite = 1; dataadr = $urandom; writedata = $urandom;
                    cyc();
                    memwrite = 0;
                end
                push(32'h40 + 32'(4 * $urandom_range(0, 7)), $urandom_range(0, 15));
            end
            do_start();
            for (int c = 0; c < 80 && !m_done; c++) begin
                r = $urandom_range(0, 99);
                if (mq.size() > 0) begin
                    a = mq[0][63:32];
                    d = mq[0][31:0];
                end else begin
                    a = $urandom; d = $urandom;
                end
                if (r < 50) store(a, d);
                else if (r < 58) store(a, d ^ (32'h1 << $urandom_range(0, 31)));
                else if (r < 62) store(a ^ 32'h4, d);
                else if (r < 75) store(SKIP, $urandom);
                else if (r < 80) push($urandom, $urandom);
                else cyc();
            end
            repeat (3) begin
                memwrite = 1; dataadr = $urandom; writedata = $urandom; exp_load = 1; start = 1;
                cyc();
                memwrite = 0; exp_load = 0; start = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
